// File: rtl/store_pack_unit_pkg.sv
// store_pkg: store type codes and packed store-buffer entry shared by the store pack slice
package store_pkg;
  localparam logic [1:0] ST_SW  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SB  = 2'b10;
  localparam logic [1:0] ST_RSV = 2'b11;
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } store_entry_t;
endpackage

// File: rtl/store_pack_unit_if.sv
// store_pack_unit_if: store request and data-memory write handshakes
interface store_pack_unit_if;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        st_err;
  modport slave(input st_valid, st_type, st_addr, st_data, mem_ready,
                output st_ready, mem_valid, mem_addr, mem_wdata, mem_be, st_err);
  modport master(output st_valid, st_type, st_addr, st_data, mem_ready,
                 input st_ready, mem_valid, mem_addr, mem_wdata, mem_be, st_err);
endinterface

// File: rtl/store_pack_unit_packer.sv
// store_lane_packer: replicates store data across lanes and derives byte enables and misalignment
module store_lane_packer
  import store_pkg::*;
(
  input  logic [1:0]  st_type,
  input  logic [1:0]  a,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);
  always_comb begin
    wdata = st_type == ST_SB ? {4{data[7:0]}} : st_type == ST_SH ? {2{data[15:0]}} : data;
    be = st_type == ST_SB ? 4'b0001 << a : st_type == ST_SH ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    misaligned = (st_type == ST_SW && a != 2'b00) || (st_type == ST_SH && a[0]);
  end
endmodule

// File: rtl/store_pack_unit.sv
// store_pack_unit: packs sw/sh/sb stores into a DEPTH-entry FIFO of word writes; STORE_ALIGN_CHECK_EN rejects misaligned stores
module store_pack_unit
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic reset,
  store_pack_unit_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  store_entry_t mem_q [DEPTH];
  store_entry_t head;
  logic [AW-1:0] wr, rd;
  logic [CW-1:0] count;
  logic [31:0] wdata;
  logic [3:0] be;
  logic misaligned, reject, push, pop, enq;
  store_lane_packer u_pack (
    .st_type(s.st_type),
    .a(s.st_addr[1:0]),
    .data(s.st_data),
    .wdata(wdata),
    .be(be),
    .misaligned(misaligned)
  );
`ifdef STORE_ALIGN_CHECK_EN
  assign reject = s.st_type == ST_RSV || misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign reject = s.st_type == ST_RSV;
`endif
  assign s.st_ready = count != CW'(DEPTH);
  assign s.mem_valid = count != '0;
  assign push = s.st_valid && s.st_ready;
  assign pop = s.mem_valid && s.mem_ready;
  assign enq = push && !reject;
  assign head = mem_q[rd];
  assign s.mem_addr = s.mem_valid ? {head.addr, 2'b00} : '0;
  assign s.mem_wdata = s.mem_valid ? head.wdata : '0;
  assign s.mem_be = s.mem_valid ? head.be : '0;
  always_ff @(posedge clk)
    if (enq) mem_q[wr] <= '{addr: s.st_addr[31:2], wdata: wdata, be: be};
  always_ff @(posedge clk) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
      s.st_err <= 1'b0;
    end else begin
      if (enq) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(enq) - CW'(pop);
      s.st_err <= push && reject;
    end
  end
endmodule

// File: tb/tb_store_pack_unit.sv
// tb_store_pack_unit: table vectors, directed corner sequences and random traffic against a queue model
module tb_store_pack_unit;
  localparam int DEPTH = 2;
  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} exp_t;
  typedef struct {logic [1:0] t; logic [31:0] a; logic [31:0] d; logic [31:0] ea; logic [31:0] ew; logic [3:0] eb; logic ee;} vec_t;
  logic clk = 0, reset = 1;
  int total = 0, bad = 0;
  exp_t q[$];
  logic err_exp = 0;
  vec_t vt[8];
  store_pack_unit_if bus();
  store_pack_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .s(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  function automatic logic rej(input logic [1:0] t, input logic [31:0] a);
`ifdef STORE_ALIGN_CHECK_EN
    return t == 2'b11 || (t == 2'b00 && a[1:0] != 0) || (t == 2'b01 && a[0]);
`else
    return t == 2'b11;
`endif
  endfunction
  function automatic exp_t pack(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a - (a % 4);
    e.be = 4'b0000;
    if (t == 2'b10) begin
      e.wdata = d[7:0] * 32'h01010101;
      e.be[a[1:0]] = 1'b1;
    end else if (t == 2'b01) begin
      e.wdata = d[15:0] * 32'h00010001;
      e.be[{a[1], 1'b0}] = 1'b1;
      e.be[{a[1], 1'b1}] = 1'b1;
    end else begin
      e.wdata = d;
      e.be = 4'b1111;
    end
    return e;
  endfunction
  task automatic check();
    exp_t h;
    h = '{addr: 0, wdata: 0, be: 0};
    if (q.size() > 0) h = q[0];
    chk("st_ready", 32'(bus.st_ready), 32'(q.size() < DEPTH));
    chk("mem_valid", 32'(bus.mem_valid), 32'(q.size() > 0));
    chk("mem_addr", bus.mem_addr, h.addr);
    chk("mem_wdata", bus.mem_wdata, h.wdata);
    chk("mem_be", 32'(bus.mem_be), 32'(h.be));
    chk("st_err", 32'(bus.st_err), 32'(err_exp));
  endtask
  task automatic step(input logic v, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                      input logic r, input logic rs);
    bit psh, pp;
    @(posedge clk);
    #1;
    bus.st_valid = v; bus.st_type = t; bus.st_addr = a; bus.st_data = d; bus.mem_ready = r; reset = rs;
    @(negedge clk);
    check();
    if (rs) begin
      q.delete();
      err_exp = 0;
    end else begin
      psh = v && q.size() < DEPTH;
      pp = q.size() > 0 && r;
      if (pp) void'(q.pop_front());
      err_exp = psh && rej(t, a);
      if (psh && !rej(t, a)) q.push_back(pack(t, a, d));
    end
  endtask
  initial begin
    vt[0] = '{2'b10, 32'h1003, 32'h000000AB, 32'h1000, 32'hABABABAB, 4'b1000, 0};
    vt[1] = '{2'b01, 32'h2002, 32'h00001234, 32'h2000, 32'h12341234, 4'b1100, 0};
    vt[2] = '{2'b00, 32'h3000, 32'hDEADBEEF, 32'h3000, 32'hDEADBEEF, 4'b1111, 0};
    vt[3] = '{2'b10, 32'h4001, 32'h1234565A, 32'h4000, 32'h5A5A5A5A, 4'b0010, 0};
    vt[4] = '{2'b01, 32'h5000, 32'hFFFFBEEF, 32'h5000, 32'hBEEFBEEF, 4'b0011, 0};
    vt[5] = '{2'b11, 32'h6000, 32'h00000011, 32'h0, 32'h0, 4'b0000, 1};
`ifdef STORE_ALIGN_CHECK_EN
    vt[6] = '{2'b00, 32'h1001, 32'hCAFEF00D, 32'h0, 32'h0, 4'b0000, 1};
    vt[7] = '{2'b01, 32'h2001, 32'h00001357, 32'h0, 32'h0, 4'b0000, 1};
`else
    vt[6] = '{2'b00, 32'h1001, 32'hCAFEF00D, 32'h1000, 32'hCAFEF00D, 4'b1111, 0};
    vt[7] = '{2'b01, 32'h2001, 32'h00001357, 32'h2000, 32'h13571357, 4'b0011, 0};
`endif
    bus.st_valid = 0; bus.st_type = 0; bus.st_addr = 0; bus.st_data = 0; bus.mem_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check();
    for (int i = 0; i < 8; i++) begin
      step(1, vt[i].t, vt[i].a, vt[i].d, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("vec_valid", 32'(bus.mem_valid), 32'(!vt[i].ee));
      chk("vec_addr", bus.mem_addr, vt[i].ea);
      chk("vec_wdata", bus.mem_wdata, vt[i].ew);
      chk("vec_be", 32'(bus.mem_be), 32'(vt[i].eb));
      chk("vec_err", 32'(bus.st_err), 32'(vt[i].ee));
      step(0, 0, 0, 0, 1, 0);
    end
    step(1, 2'b01, 32'h2002, 32'h1234, 0, 0);
    step(1, 2'b00, 32'h3000, 32'hDEADBEEF, 0, 0);
    step(1, 2'b10, 32'h7002, 32'h77, 0, 0);
    chk("full_ready", 32'(bus.st_ready), 0);
    step(1, 2'b10, 32'h7002, 32'h77, 0, 0);
    step(1, 2'b10, 32'h7002, 32'h77, 1, 0);
    chk("full_pop_ready", 32'(bus.st_ready), 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 1, 0);
    chk("drained", 32'(bus.mem_valid), 0);
    for (int i = 0; i < 11; i++) begin
      step(1, 2'b00, 32'h8000 + 32'(i * 4), 32'(i), 1, 0);
      if (i > 0) chk("steady_one", {30'b0, bus.mem_valid, bus.st_ready}, 32'b11);
    end
    step(0, 0, 0, 0, 1, 0);
    step(1, 2'b10, 32'h9000, 32'h1, 0, 0);
    step(1, 2'b10, 32'h9001, 32'h2, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(bus.mem_valid), 0);
    chk("rst_ready", 32'(bus.st_ready), 1);
    chk("rst_be", 32'(bus.mem_be), 0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
